// File: rtl/bcd_timer_counter_mod_n.sv
// Two-digit BCD up/down counter, modulo MODULUS, with load, run/pause control and
// stop-or-reload on expiry. Advances only on the single-cycle clk_time tick.
module bcd_timer_counter_mod_n #(
  parameter int unsigned MODULUS     = 60,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_time,
  input  logic       load_enable,
  input  logic [3:0] set_value1,
  input  logic [3:0] set_value10,
  input  logic       up_down,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] dec1,
  output logic [3:0] dec10,
  output logic       wrap_pulse,
  output logic       running,
  output logic       done,
  output logic       zero,
  output logic       load_err
);

  localparam logic [3:0] TOP1  = 4'((MODULUS - 1) % 10);
  localparam logic [3:0] TOP10 = 4'((MODULUS - 1) / 10);
  localparam logic [7:0] MOD8  = 8'(MODULUS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] dec1_q, dec1_d, dec10_q, dec10_d;
  logic [3:0] rel1_q, rel1_d, rel10_q, rel10_d;
  logic       wrap_q, wrap_d, lerr_q, lerr_d;

  logic       at_zero, at_top, tick_run, expire, load_bad;
  logic [7:0] load_val;
  logic [3:0] ld1, ld10;

  assign at_zero  = (dec1_q == 4'd0) && (dec10_q == 4'd0);
  assign at_top   = (dec1_q == TOP1) && (dec10_q == TOP10);
  // A load on the same edge swallows the tick.
  assign tick_run = clk_time && !load_enable && (state_q == StRun);
  assign expire   = tick_run && !up_down && at_zero && !AUTO_RELOAD;

  assign load_val = {4'd0, set_value10} * 8'd10 + {4'd0, set_value1};
  assign load_bad = (set_value1 > 4'd9) || (set_value10 > 4'd9) || (load_val >= MOD8);
  assign ld1      = load_bad ? TOP1 : set_value1;
  assign ld10     = load_bad ? TOP10 : set_value10;

  // State register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop dominates start; expiry only when no control pulse intervenes.
  always_comb begin
    state_d = state_q;
    if (start && stop) begin
      state_d = StIdle;
    end else if (stop && (state_q == StRun)) begin
      state_d = StIdle;
    end else if (start && (state_q != StRun)) begin
      state_d = StRun;
    end else if (load_enable && (state_q == StDone)) begin
      state_d = StIdle;
    end else if (expire) begin
      state_d = StDone;
    end
  end

  // State outputs
  always_comb begin
    running = (state_q == StRun);
    done    = (state_q == StDone);
  end

  // Count datapath
  always_comb begin
    dec1_d  = dec1_q;
    dec10_d = dec10_q;
    rel1_d  = rel1_q;
    rel10_d = rel10_q;
    wrap_d  = 1'b0;
    lerr_d  = 1'b0;
    if (load_enable) begin
      dec1_d  = ld1;
      dec10_d = ld10;
      rel1_d  = ld1;
      rel10_d = ld10;
      lerr_d  = load_bad;
    end else if (tick_run) begin
      if (up_down) begin
        if (at_top) begin
          dec1_d  = 4'd0;
          dec10_d = 4'd0;
          wrap_d  = 1'b1;
        end else if (dec1_q == 4'd9) begin
          dec1_d  = 4'd0;
          dec10_d = dec10_q + 4'd1;
        end else begin
          dec1_d = dec1_q + 4'd1;
        end
      end else if (at_zero) begin
        wrap_d = 1'b1;
        if (AUTO_RELOAD) begin
          dec1_d  = rel1_q;
          dec10_d = rel10_q;
        end
      end else if (dec1_q == 4'd0) begin
        dec1_d  = 4'd9;
        dec10_d = dec10_q - 4'd1;
      end else begin
        dec1_d = dec1_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      dec1_q  <= 4'd0;
      dec10_q <= 4'd0;
      rel1_q  <= 4'd0;
      rel10_q <= 4'd0;
      wrap_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      dec1_q  <= dec1_d;
      dec10_q <= dec10_d;
      rel1_q  <= rel1_d;
      rel10_q <= rel10_d;
      wrap_q  <= wrap_d;
      lerr_q  <= lerr_d;
    end
  end

  assign dec1       = dec1_q;
  assign dec10      = dec10_q;
  assign wrap_pulse = wrap_q;
  assign load_err   = lerr_q;
  assign zero       = at_zero;

endmodule

// File: tb/tb_bcd_timer_counter_mod_n.sv
// Bench for bcd_timer_counter_mod_n: three instances (M60, M60 auto-reload, M24) share
// stimulus; an integer-valued model feeds a scoreboard checked by a negedge monitor.
module tb_bcd_timer_counter_mod_n;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       clk_time = 1'b0, load_enable = 1'b0, up_down = 1'b0, start = 1'b0, stop = 1'b0;
  logic [3:0] set_value1 = 4'd0, set_value10 = 4'd0;

  logic [3:0] dec1 [N];
  logic [3:0] dec10 [N];
  logic       wrap_pulse [N];
  logic       running [N];
  logic       done [N];
  logic       zero [N];
  logic       load_err [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    bcd_timer_counter_mod_n #(
      .MODULUS     ((g == 2) ? 24 : 60),
      .AUTO_RELOAD ((g == 1) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk         (clk),
      .reset_p     (reset_p),
      .clk_time    (clk_time),
      .load_enable (load_enable),
      .set_value1  (set_value1),
      .set_value10 (set_value10),
      .up_down     (up_down),
      .start       (start),
      .stop        (stop),
      .dec1        (dec1[g]),
      .dec10       (dec10[g]),
      .wrap_pulse  (wrap_pulse[g]),
      .running     (running[g]),
      .done        (done[g]),
      .zero        (zero[g]),
      .load_err    (load_err[g])
    );
  end

  always #5 clk = ~clk;

  int mods [N] = '{60, 60, 24};
  bit ar [N]   = '{1'b0, 1'b1, 1'b0};

  // Model: value as an integer, state 0 = idle, 1 = run, 2 = done.
  int v [N];
  int rel [N];
  int st [N];

  typedef logic [N-1:0][12:0] exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [12:0] outs(int i);
    return {dec10[i], dec1[i], wrap_pulse[i], running[i], done[i], zero[i], load_err[i]};
  endfunction

  function automatic void check(string name, int i, logic [12:0] act, logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d t=%0t: got V=%h%h w/run/done/zero/lerr=%b, expected V=%h%h %b",
               name, i, $time, act[12:9], act[8:5], act[4:0], exp[12:9], exp[8:5], exp[4:0]);
    end
  endfunction

  task automatic step(input logic ld, input logic [3:0] s1, input logic [3:0] s10,
                      input logic tk, input logic ud, input logic sa, input logic so);
    exp_t e;
    int   nv [N];
    int   nrel [N];
    int   nst [N];
    int   val;
    bit   w, le;
    load_enable = ld;
    set_value1  = s1;
    set_value10 = s10;
    clk_time    = tk;
    up_down     = ud;
    start       = sa;
    stop        = so;
    for (int i = 0; i < N; i++) begin
      nv[i]   = v[i];
      nrel[i] = rel[i];
      nst[i]  = st[i];
      w       = 1'b0;
      le      = 1'b0;
      if (ld) begin
        val = 10 * int'(s10) + int'(s1);
        if (s1 > 9 || s10 > 9 || val >= mods[i]) begin
          val = mods[i] - 1;
          le  = 1'b1;
        end
        nv[i]   = val;
        nrel[i] = val;
      end else if (tk && st[i] == 1) begin
        if (ud) begin
          nv[i] = (v[i] + 1) % mods[i];
          w     = (v[i] == mods[i] - 1);
        end else if (v[i] > 0) begin
          nv[i] = v[i] - 1;
        end else begin
          w     = 1'b1;
          nv[i] = ar[i] ? rel[i] : 0;
        end
      end
      if (sa && so) nst[i] = 0;
      else if (so && st[i] == 1) nst[i] = 0;
      else if (sa && st[i] != 1) nst[i] = 1;
      else if (ld && st[i] == 2) nst[i] = 0;
      else if (!ld && tk && st[i] == 1 && !ud && v[i] == 0 && !ar[i]) nst[i] = 2;
      e[i] = {4'(nv[i] / 10), 4'(nv[i] % 10), w, nst[i] == 1, nst[i] == 2, nv[i] == 0, le};
    end
    @(posedge clk);
    sb.push_back(e);
    for (int i = 0; i < N; i++) begin
      v[i]   = nv[i];
      rel[i] = nrel[i];
      st[i]  = nst[i];
    end
    #1;
  endtask

  task automatic tick(input logic ud);
    step(1'b0, 4'd0, 4'd0, 1'b1, ud, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, ud, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle is an output beat.
  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        me = sb.pop_front();
        for (int i = 0; i < N; i++) check("cycle", i, outs(i), me[i]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit         last_tk;
    logic       ud, ld, tk, sa, so;
    logic [3:0] s1, s10;
    for (int i = 0; i < N; i++) begin
      v[i] = 0; rel[i] = 0; st[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) check("reset", i, outs(i), 13'h002);
    reset_p = 1'b0;

    // Load 05 and start, count down through expiry.
    step(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) tick(1'b0);
    // Load 58 from done with start, count up across the wrap.
    step(1'b1, 4'd8, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) tick(1'b1);
    // Load 03 while running, count down to reload/expiry.
    step(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) tick(1'b0);
    // Out-of-range loads clamp.
    step(1'b1, 4'd5, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hA, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // 23 up: wraps for M=24.
    step(1'b1, 4'd3, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) tick(1'b1);
    // Load with tick discards the tick; stop+start goes idle; idle ignores ticks.
    step(1'b1, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) tick(1'b0);

    // Asynchronous reset mid-run.
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0);
    @(negedge clk);
    #1;
    reset_p = 1'b1;
    #1;
    for (int i = 0; i < N; i++) check("async_reset", i, outs(i), 13'h002);
    for (int i = 0; i < N; i++) begin
      v[i] = 0; rel[i] = 0; st[i] = 0;
    end
    @(posedge clk);
    #1;
    reset_p = 1'b0;
    tick(1'b0);
    step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0);

    // Random phase.
    last_tk = 1'b0;
    ud      = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      ld  = ($urandom % 16 == 0);
      s1  = ($urandom % 6 == 0) ? 4'($urandom) : 4'($urandom % 10);
      s10 = ($urandom % 6 == 0) ? 4'($urandom) : 4'($urandom % 6);
      tk  = !last_tk && ($urandom % 3 == 0);
      if ($urandom % 25 == 0) ud = ~ud;
      sa  = ($urandom % 15 == 0);
      so  = ($urandom % 30 == 0);
      step(ld, s1, s10, tk, ud, sa, so);
      last_tk = tk;
    end
    step(1'b0, 4'd0, 4'd0, 1'b0, ud, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected beats left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
